// File: rtl/me_feeder_pkg.sv
// Shared types and constants for the motion-estimation row feeder.
// Pixel/word geometry and the feeder FSM state encoding live here.
package me_feeder_pkg;

  localparam int PIX_W      = 8;
  localparam int WORD_W     = 32;
  localparam int LOAD_WORDS = 4;
  localparam int PAIR_W     = 16;
  localparam int ROW_W      = LOAD_WORDS * WORD_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } feeder_state_e;

  // Earlier pixel pair of a word sits in the low half (byte 0 is earliest).
  function automatic logic [PAIR_W-1:0] word_pair(input logic [WORD_W-1:0] w,
                                                  input logic hi);
    return hi ? w[WORD_W-1:PAIR_W] : w[PAIR_W-1:0];
  endfunction

endpackage

// File: rtl/me_word_buf.sv
// Two-entry 32-bit word FIFO holding fetched stream words until their
// pixel pairs drain. Push and pop may coincide in the same cycle.
module me_word_buf
  import me_feeder_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] head_o,
  output logic [1:0]        count_o
);

  logic [WORD_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              do_push;
  logic              do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/me_row_feeder.sv
// Reference-row feeder: 4-word initial window load, then a pixel-pair stream.
// Optional stall counter output is enabled by defining ME_FEEDER_STALL_CNT_EN.
module me_row_feeder
  import me_feeder_pkg::*;
#(
  parameter int ROW_WORDS = 8,
  parameter int ADDR_W    = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic              row_load_o,
  output logic [ROW_W-1:0]  row_data_o,
  output logic              pair_valid_o,
  output logic [PAIR_W-1:0] pair_data_o,
  input  logic              pair_ready_i,
  output logic              busy_o,
  output logic              done_o
`ifdef ME_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt_o
`endif
);

  localparam int CNT_W = $clog2(ROW_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(LOAD_WORDS - 1);
  localparam logic [CNT_W-1:0] LOAD_CNT  = CNT_W'(LOAD_WORDS);
  localparam logic [CNT_W-1:0] ROW_CNT   = CNT_W'(ROW_WORDS);

  feeder_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              ld_pend_q;
  logic              st_pend_q;
  logic [1:0]        ld_rx_q;
  logic              half_q;
  logic              row_load_q;
  logic [ROW_W-1:0]  row_q;

  logic              ld_req;
  logic              st_req;
  logic              start_acc;
  logic              pair_fire;
  logic              last_fire;
  logic [WORD_W-1:0] buf_head;
  logic [1:0]        buf_cnt;

  me_word_buf u_word_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (st_pend_q),
    .push_data_i (mem_rdata_i),
    .pop_i       (pair_fire && half_q),
    .head_o      (buf_head),
    .count_o     (buf_cnt)
  );

  assign pair_valid_o = (buf_cnt != 2'd0);
  assign pair_fire    = pair_valid_o && pair_ready_i;
  assign last_fire    = pair_fire && half_q && (buf_cnt == 2'd1) &&
                        !st_pend_q && (rd_cnt_q == ROW_CNT);

  // Stream reads are throttled so fetched-plus-in-flight words never exceed two.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_cnt_d  = rd_cnt_q;
    ld_req    = 1'b0;
    st_req    = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = LOAD;
          addr_d    = base_addr_i;
          rd_cnt_d  = '0;
        end
      end
      LOAD: begin
        ld_req = (rd_cnt_q < LOAD_CNT);
        if (ld_req && (rd_cnt_q == LAST_LOAD) && (ROW_WORDS > LOAD_WORDS)) begin
          state_d = STREAM;
        end else if (row_load_q) begin
          state_d = DONE;
        end
      end
      STREAM: begin
        st_req = (rd_cnt_q != ROW_CNT) &&
                 (({1'b0, buf_cnt} + {2'b00, st_pend_q}) < 3'd2);
        if (last_fire) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (ld_req || st_req) begin
      addr_d   = addr_q + 1'b1;
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rd_cnt_q   <= '0;
      ld_pend_q  <= 1'b0;
      st_pend_q  <= 1'b0;
      ld_rx_q    <= 2'd0;
      half_q     <= 1'b0;
      row_load_q <= 1'b0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_cnt_q   <= rd_cnt_d;
      ld_pend_q  <= ld_req;
      st_pend_q  <= st_req;
      row_load_q <= 1'b0;
      if (start_acc) begin
        ld_rx_q <= 2'd0;
      end else if (ld_pend_q) begin
        // Shifting in from the top leaves word 0 in the low bits after 4 words.
        row_q   <= {mem_rdata_i, row_q[ROW_W-1:WORD_W]};
        ld_rx_q <= ld_rx_q + 2'd1;
        if (ld_rx_q == 2'd3) begin
          row_load_q <= 1'b1;
        end
      end
      if (pair_fire) begin
        half_q <= ~half_q;
      end
    end
  end

`ifdef ME_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= 16'd0;
    end else if (start_acc) begin
      stall_cnt_q <= 16'd0;
    end else if (pair_valid_o && !pair_ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign mem_req_o   = ld_req || st_req;
  assign mem_addr_o  = addr_q;
  assign row_load_o  = row_load_q;
  assign row_data_o  = row_q;
  assign pair_data_o = pair_valid_o ? word_pair(buf_head, half_q) : '0;
  assign busy_o      = (state_q == LOAD) || (state_q == STREAM);
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_me_row_feeder.sv
// Bench for me_row_feeder: an 8-word instance and a 4-word instance against
// a pixel-formula memory, with expectations rebuilt from a logged event trace.
module tb_me_row_feeder;

  localparam int K_READ  = 0;
  localparam int K_LOAD  = 1;
  localparam int K_PAIR  = 2;
  localparam int K_DONE  = 3;
  localparam int K_VALID = 4;

  localparam int M_NOM  = 0;
  localparam int M_BP   = 1;
  localparam int M_COLL = 2;
  localparam int M_RAND = 3;
  localparam int M_RST  = 4;

  typedef struct {
    int           dut;
    int           kind;
    int           cyc;
    logic [127:0] data;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         startA, startB, ready;
  logic [11:0]  baseAddr;

  logic         aReq, aLoad, aValid, aBusy, aDone;
  logic [11:0]  aAddr;
  logic [31:0]  aRdata;
  logic [127:0] aRowData;
  logic [15:0]  aPairData;
  logic         bReq, bLoad, bValid, bBusy, bDone;
  logic [11:0]  bAddr;
  logic [31:0]  bRdata;
  logic [127:0] bRowData;
  logic [15:0]  bPairData;
`ifdef ME_FEEDER_STALL_CNT_EN
  logic [15:0]  aStallCnt, bStallCnt;
`endif

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   holdErr = 0;
  logic aPrevStall = 1'b0;
  logic [15:0] aPrevData = '0;
  ev_t  evLog[$];

  always #5 clk = ~clk;

  me_row_feeder #(.ROW_WORDS(8), .ADDR_W(12)) dutA (
    .clk_i(clk), .rst_i(rst), .start_i(startA), .base_addr_i(baseAddr),
    .mem_req_o(aReq), .mem_addr_o(aAddr), .mem_rdata_i(aRdata),
    .row_load_o(aLoad), .row_data_o(aRowData),
    .pair_valid_o(aValid), .pair_data_o(aPairData), .pair_ready_i(ready),
    .busy_o(aBusy), .done_o(aDone)
`ifdef ME_FEEDER_STALL_CNT_EN
    , .stall_cnt_o(aStallCnt)
`endif
  );

  me_row_feeder #(.ROW_WORDS(4), .ADDR_W(12)) dutB (
    .clk_i(clk), .rst_i(rst), .start_i(startB), .base_addr_i(baseAddr),
    .mem_req_o(bReq), .mem_addr_o(bAddr), .mem_rdata_i(bRdata),
    .row_load_o(bLoad), .row_data_o(bRowData),
    .pair_valid_o(bValid), .pair_data_o(bPairData), .pair_ready_i(ready),
    .busy_o(bBusy), .done_o(bDone)
`ifdef ME_FEEDER_STALL_CNT_EN
    , .stall_cnt_o(bStallCnt)
`endif
  );

  function automatic logic [31:0] memWord(input logic [11:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      w[8*k +: 8] = 8'((32'(a) * 4 + k) & 255);
    end
    return w;
  endfunction

  // Memory returns garbage when not read so stray captures are visible.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    aRdata <= aReq ? memWord(aAddr) : 32'($urandom);
    bRdata <= bReq ? memWord(bAddr) : 32'($urandom);
  end

  always @(negedge clk) begin
    if (rst) begin
      aPrevStall <= 1'b0;
    end else begin
      if (aReq)  evLog.push_back('{dut: 0, kind: K_READ, cyc: cyc, data: 128'(aAddr)});
      if (aLoad) evLog.push_back('{dut: 0, kind: K_LOAD, cyc: cyc, data: aRowData});
      if (aValid && ready) evLog.push_back('{dut: 0, kind: K_PAIR, cyc: cyc, data: 128'(aPairData)});
      if (aDone) evLog.push_back('{dut: 0, kind: K_DONE, cyc: cyc, data: '0});
      if (bReq)  evLog.push_back('{dut: 1, kind: K_READ, cyc: cyc, data: 128'(bAddr)});
      if (bLoad) evLog.push_back('{dut: 1, kind: K_LOAD, cyc: cyc, data: bRowData});
      if (bValid) evLog.push_back('{dut: 1, kind: K_VALID, cyc: cyc, data: 128'(bPairData)});
      if (bDone) evLog.push_back('{dut: 1, kind: K_DONE, cyc: cyc, data: '0});
      if (aPrevStall && (!aValid || aPairData !== aPrevData)) holdErr <= holdErr + 1;
      aPrevStall <= aValid && !ready;
      aPrevData  <= aPairData;
    end
  end

  function automatic int countEv(input int dut, input int kind, input int after);
    int n;
    n = 0;
    foreach (evLog[i]) begin
      if (evLog[i].dut == dut && evLog[i].kind == kind && evLog[i].cyc > after) n++;
    end
    return n;
  endfunction

  function automatic logic readyFor(input int mode, input int r);
    case (mode)
      M_BP:    return !(r >= 7 && r <= 11);
      M_RAND:  return ($urandom_range(0, 3) != 0);
      default: return 1'b1;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts a row (or adopts one already started this cycle) and runs it to its end.
  task automatic applyStimulus(input int dut, input logic [11:0] base, input int mode,
                               input bit already, output int s);
    bit fin;
    if (!already) begin
      baseAddr = base;
      if (dut == 0) startA = 1'b1;
      else          startB = 1'b1;
    end
    s     = cyc;
    ready = readyFor(mode, 0);
    fin   = 1'b0;
    for (int r = 1; r < 200 && !fin; r++) begin
      @(posedge clk); #1;
      startA = 1'b0;
      startB = 1'b0;
      ready  = readyFor(mode, r);
      if (mode == M_COLL && r == 9) begin
        startA   = 1'b1;
        baseAddr = 12'h300;
      end
      if (mode == M_COLL && r == 15) begin
        startA   = 1'b1;
        baseAddr = 12'h020;
        fin      = 1'b1;
      end
      if (mode == M_RST && countEv(dut, K_PAIR, s) >= 3) fin = 1'b1;
      if (mode != M_COLL && mode != M_RST && countEv(dut, K_DONE, s) > 0) fin = 1'b1;
    end
    checkOutput($sformatf("bound.dut%0d.mode%0d", dut, mode), 128'(fin), 128'd1);
  endtask

  task automatic verifyRow(input int dut, input int s, input logic [11:0] base,
                           input int rw, input int mode, input string tag);
    ev_t rd[$];
    ev_t ld[$];
    ev_t pr[$];
    int d, nValid, maxOcc, nr, np, off;
    logic [11:0]  ea;
    logic [31:0]  w;
    logic [127:0] expRow;
    d = -1;
    nValid = 0;
    foreach (evLog[i]) begin
      if (evLog[i].dut == dut && evLog[i].kind == K_DONE && evLog[i].cyc > s && d < 0)
        d = evLog[i].cyc;
    end
    checkOutput({tag, ".doneSeen"}, 128'(d >= 0), 128'd1);
    if (d < 0) return;
    foreach (evLog[i]) begin
      if (evLog[i].dut == dut && evLog[i].cyc > s && evLog[i].cyc <= d) begin
        if (evLog[i].kind == K_READ)  rd.push_back(evLog[i]);
        if (evLog[i].kind == K_LOAD)  ld.push_back(evLog[i]);
        if (evLog[i].kind == K_PAIR)  pr.push_back(evLog[i]);
        if (evLog[i].kind == K_VALID) nValid++;
      end
    end
    checkOutput({tag, ".nReads"}, 128'(rd.size()), 128'(rw));
    for (int i = 0; i < rd.size() && i < rw; i++) begin
      ea = base + 12'(i);
      checkOutput($sformatf("%s.addr%0d", tag, i), rd[i].data, 128'(ea));
      if (i < 4) checkOutput($sformatf("%s.ldCyc%0d", tag, i), 128'(rd[i].cyc), 128'(s + 1 + i));
    end
    if (rw > 4 && rd.size() > 4) checkOutput({tag, ".stCyc0"}, 128'(rd[4].cyc), 128'(s + 5));
    for (int i = 0; i < 4; i++) expRow[32*i +: 32] = memWord(base + 12'(i));
    checkOutput({tag, ".nLoads"}, 128'(ld.size()), 128'd1);
    if (ld.size() > 0) begin
      checkOutput({tag, ".loadCyc"}, 128'(ld[0].cyc), 128'(s + 6));
      checkOutput({tag, ".rowData"}, ld[0].data, expRow);
    end
    checkOutput({tag, ".nPairs"}, 128'(pr.size()), 128'(2 * (rw - 4)));
    off = (mode == M_BP) ? 12 : 7;
    for (int k = 0; k < pr.size() && k < 2 * (rw - 4); k++) begin
      w = memWord(base + 12'(4 + k / 2));
      checkOutput($sformatf("%s.pair%0d", tag, k), pr[k].data,
                  128'((k % 2 == 1) ? w[31:16] : w[15:0]));
      if (mode != M_RAND)
        checkOutput($sformatf("%s.pairCyc%0d", tag, k), 128'(pr[k].cyc), 128'(s + off + k));
    end
    if (rw == 4) begin
      checkOutput({tag, ".doneCyc"}, 128'(d), 128'(s + 7));
      checkOutput({tag, ".noValid"}, 128'(nValid), 128'd0);
    end else if (pr.size() > 0) begin
      checkOutput({tag, ".doneCyc"}, 128'(d), 128'(pr[pr.size() - 1].cyc + 1));
      maxOcc = 0;
      for (int c = s + 1; c <= d; c++) begin
        nr = 0;
        np = 0;
        for (int i = 4; i < rd.size(); i++) if (rd[i].cyc <= c) nr++;
        foreach (pr[k]) if (pr[k].cyc < c) np++;
        if (nr - np / 2 > maxOcc) maxOcc = nr - np / 2;
      end
      checkOutput({tag, ".occupancy"}, 128'(maxOcc <= 2), 128'd1);
    end
  endtask

  initial begin
    int s, s2, rc;
    logic [11:0] rb;
    rst = 1'b1; startA = 1'b0; startB = 1'b0; ready = 1'b0; baseAddr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.a", 128'({aReq, aLoad, aValid, aBusy, aDone, aPairData, aAddr}), 128'd0);
    checkOutput("reset.aRow", aRowData, 128'd0);
    checkOutput("reset.b", 128'({bReq, bLoad, bValid, bBusy, bDone, bPairData, bAddr}), 128'd0);
`ifdef ME_FEEDER_STALL_CNT_EN
    checkOutput("reset.stall", 128'(aStallCnt), 128'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] nominal row");
    applyStimulus(0, 12'h010, M_NOM, 1'b0, s);
    verifyRow(0, s, 12'h010, 8, M_NOM, "nom");

    $display("[TB] backpressure row");
    applyStimulus(0, 12'h010, M_BP, 1'b0, s);
    verifyRow(0, s, 12'h010, 8, M_BP, "bp");
    checkOutput("bp.hold", 128'(holdErr), 128'd0);
`ifdef ME_FEEDER_STALL_CNT_EN
    checkOutput("bp.stallCnt", 128'(aStallCnt), 128'd5);
`endif

    $display("[TB] address wrap");
    applyStimulus(0, 12'hFFE, M_NOM, 1'b0, s);
    verifyRow(0, s, 12'hFFE, 8, M_NOM, "wrap");

    $display("[TB] start collisions");
    applyStimulus(0, 12'h010, M_COLL, 1'b0, s);
    applyStimulus(0, 12'h020, M_NOM, 1'b1, s2);
    verifyRow(0, s, 12'h010, 8, M_NOM, "coll1");
    verifyRow(0, s2, 12'h020, 8, M_NOM, "coll2");

    $display("[TB] reset mid-row");
    applyStimulus(0, 12'h010, M_RST, 1'b0, s);
    rst = 1'b1;
    rc  = cyc;
    #1;
    checkOutput("rst.outs", 128'({aReq, aLoad, aValid, aBusy, aDone, aPairData, aAddr}), 128'd0);
    checkOutput("rst.row", aRowData, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("rst.noPairs", 128'(countEv(0, K_PAIR, rc)), 128'd0);
    checkOutput("rst.noLoad", 128'(countEv(0, K_LOAD, rc)), 128'd0);
    checkOutput("rst.noDone", 128'(countEv(0, K_DONE, rc)), 128'd0);
    checkOutput("rst.idle", 128'({aBusy, aValid}), 128'd0);
    applyStimulus(0, 12'h010, M_NOM, 1'b0, s);
    verifyRow(0, s, 12'h010, 8, M_NOM, "rstNom");

    $display("[TB] four-word row");
    applyStimulus(1, 12'h040, M_NOM, 1'b0, s);
    verifyRow(1, s, 12'h040, 4, M_NOM, "rw4");

    $display("[TB] random backpressure rows");
    for (int n = 0; n < 6; n++) begin
      rb = 12'($urandom);
      applyStimulus(0, rb, M_RAND, 1'b0, s);
      verifyRow(0, s, rb, 8, M_RAND, $sformatf("rand%0d", n));
    end
    checkOutput("rand.hold", 128'(holdErr), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/me_row_feeder.md
# me_row_feeder

Upstream feeder for the motion-estimation search-window shift chain. It fetches one reference-frame row from pixel SRAM and issues a 128-bit initial window load (16 pixels). It then streams the remaining pixels as 16-bit pixel pairs over a valid/ready handshake into the first shift stage, which consumes the low byte immediately and the high byte one step later. One row is processed per `start_i`.

## Interface
- `ROW_WORDS`, 8: 32-bit words per row; ≥4; first 4 words form the initial load.
- `ADDR_W`, 12: SRAM word-address width.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: row start pulse; ignored while busy.
- `base_addr_i` in ADDR_W: word address of the row; sampled on accepted start.
- `mem_req_o` out 1: SRAM read strobe.
- `mem_addr_o` out ADDR_W: read address.
- `mem_rdata_i` in 32: read data, valid exactly 1 cycle after `mem_req_o`.
- `row_load_o` out 1: 1-cycle pulse, `row_data_o` valid.
- `row_data_o` out 128: initial window, pixel 0 in [7:0].
- `pair_valid_o` out 1, `pair_data_o` out 16, `pair_ready_i` in 1: pixel-pair stream; [7:0] is the earlier pixel.
- `busy_o` out 1: high from accepted start until `done_o`.
- `done_o` out 1: 1-cycle pulse after the last pair transfers.

## Operation
- Memory byte order: byte 0 of a word is the earliest pixel.
  - `row_data_o` = {w3,w2,w1,w0}.
  - Each stream word yields pair {b1,b0}, then pair {b3,b2}.
- FSM states:
  - IDLE: `start_i` moves to LOAD, latches the address, and clears counters.
  - LOAD: issue 4 back-to-back reads. On 4th data, register `row_data_o` and pulse `row_load_o`. If ROW_WORDS==4, move to DONE; otherwise move to STREAM.
  - STREAM: issue reads for words 4..ROW_WORDS-1 into a 2-entry word buffer. A read is issued only if (buffered words + reads in flight) < 2. Pairs drain from the buffer head.
  - DONE: pulse `done_o` and return to IDLE. `busy_o` is low in DONE.
- Handshake:
  - A transfer occurs when `pair_valid_o && pair_ready_i`.
  - While valid and not ready, `pair_data_o` holds stable and `pair_valid_o` stays high.
  - `pair_valid_o` never drops without a transfer.
- Stream reads may start in the cycle after the 4th LOAD read, overlapping the LOAD data return.
- Addresses increment modulo 2^ADDR_W; wrap is silent.
- Reset values: every output is 0; FSM is IDLE; buffer is empty; in-flight flag is cleared.
- Reset mid-row: everything clears immediately, and `mem_rdata_i` in the following cycle is discarded.

## Timing
- Accepted start at cycle 0.
- LOAD reads in cycles 1–4, data in cycles 2–5, `row_load_o` in cycle 6.
- First stream read in cycle 5, data in cycle 6, first `pair_valid_o` in cycle 7.
- Sustained throughput with `pair_ready_i` held high: 1 pair/cycle, no bubbles.
- Last transfer at cycle T gives `done_o` at T+1. A start in the `done_o` cycle is accepted.

## Configuration
- `ME_FEEDER_STALL_CNT_EN` defined:
  - Adds output `stall_cnt_o` [15:0].
  - Counts cycles with `pair_valid_o && !pair_ready_i`.
  - Clears on accepted start and on reset; saturates at 0xFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `me_feeder_pkg`:
  - State enum {IDLE, LOAD, STREAM, DONE}.
  - Constants `PIX_W`=8, `WORD_W`=32, `LOAD_WORDS`=4, `PAIR_W`=16.
- Sub-module `me_word_buf`: 2-entry 32-bit FIFO with count output, used for the stream buffer.

## Test plan
- Memory model: the pixel at word address a, byte k, has value (4a+k) mod 256.
- Nominal row, ROW_WORDS=8, base 0x010, ready held high:
  - Reads at 0x010–0x017.
  - `row_data_o` = 0x4F4E…4140, `row_load_o` in cycle 6.
  - Pairs 0x5150, 0x5352, …, 0x5F5E, 8 pairs on consecutive cycles from cycle 7.
  - `done_o` one cycle after the last pair.
- Backpressure: same row, `pair_ready_i` low for 5 cycles from cycle 7.
  - `pair_data_o` holds 0x5150.
  - At most 2 words buffered plus in flight.
  - Resumed stream is gap-free and in order.
- Wrap: ADDR_W=12, base 0xFFE → read addresses 0xFFE, 0xFFF, 0x000, 0x001, …, 0x005.
- Start collision:
  - `start_i` mid-STREAM is ignored, with no address change.
  - `start_i` in the `done_o` cycle with base 0x020 starts a new row, first read at 0x020 in the next cycle.
- Reset mid-row: `rst_i` pulse after the 3rd pair.
  - All outputs are 0 at once; the next `mem_rdata_i` is ignored.
  - A fresh start at 0x010 reproduces the nominal results.
- ROW_WORDS=4 boundary: `row_load_o` in cycle 6, no `pair_valid_o`, `done_o` in cycle 7.
- With `ME_FEEDER_STALL_CNT_EN`: after the backpressure test, `stall_cnt_o` = 5.
